// File: rtl/ov7670_config_sequencer_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer:
// FSM encoding, ROM entry tags, register names and selectable tables.
package ov7670_config_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POWERUP,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_FREE,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } seq_state_e;

  // Which case-statement table the ROM holds.
  typedef enum logic [1:0] {
    TBL_OV7670_RGB565,
    TBL_SOFT_RESET,
    TBL_WRITES_ONLY
  } cfg_table_e;

  localparam logic [15:0] CFG_SENTINEL  = 16'hFFFF;
  localparam logic [7:0]  CFG_DELAY_TAG = 8'hF0;

  localparam logic [7:0] REG_COM3   = 8'h0C;
  localparam logic [7:0] REG_CLKRC  = 8'h11;
  localparam logic [7:0] REG_COM7   = 8'h12;
  localparam logic [7:0] REG_TSLB   = 8'h3A;
  localparam logic [7:0] REG_COM14  = 8'h3E;
  localparam logic [7:0] REG_COM15  = 8'h40;
  localparam logic [7:0] REG_RGB444 = 8'h8C;

  function automatic logic [15:0] cfg_write(input logic [7:0] reg_addr, input logic [7:0] value);
    return {reg_addr, value};
  endfunction

  function automatic logic [15:0] cfg_delay(input logic [7:0] ms);
    return {CFG_DELAY_TAG, ms};
  endfunction

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// Write-request bus between the configuration sequencer and the SCCB write engine.
// o_ready is a one-cycle request; o_addr/o_data are valid from that request until i_sccb_busy falls.
// The engine accepts by raising i_sccb_busy and signals completion by dropping it.
interface ov7670_config_sequencer_if;
  logic [7:0] o_addr;
  logic [7:0] o_data;
  logic       o_ready;
  logic       i_sccb_busy;

  modport master (output o_addr, output o_data, output o_ready, input i_sccb_busy);
  modport slave  (input o_addr, input o_data, input o_ready, output i_sccb_busy);
endinterface

// File: rtl/ov7670_config_rom.sv
// Synchronous {reg, value} table ROM; entry_o is valid one cycle after index_i.
module ov7670_config_rom
  import ov7670_config_sequencer_pkg::*;
#(
  parameter cfg_table_e Table    = TBL_OV7670_RGB565,
  parameter int         RomDepth = 128,
  localparam int        IdxW     = $clog2(RomDepth)
) (
  input  logic            clk_i,
  input  logic [IdxW-1:0] index_i,
  output logic [15:0]     entry_o
);

  logic [15:0] entry_d;
  logic [15:0] entry_q;

  always_comb begin
    entry_d = CFG_SENTINEL;
    case (Table)
      TBL_SOFT_RESET: begin
        case (int'(index_i))
          0:       entry_d = cfg_write(REG_COM7, 8'h80);
          1:       entry_d = cfg_delay(8'd1);
          2:       entry_d = cfg_write(REG_CLKRC, 8'h01);
          default: entry_d = CFG_SENTINEL;
        endcase
      end
      TBL_WRITES_ONLY: begin
        case (int'(index_i))
          0:       entry_d = cfg_write(REG_CLKRC, 8'h01);
          1:       entry_d = cfg_write(REG_TSLB, 8'h04);
          2:       entry_d = cfg_write(REG_COM15, 8'hD0);
          3:       entry_d = cfg_write(REG_RGB444, 8'h00);
          default: entry_d = CFG_SENTINEL;
        endcase
      end
      default: begin
        // Soft reset needs ~10 ms before the sensor accepts further writes.
        case (int'(index_i))
          0:       entry_d = cfg_write(REG_COM7, 8'h80);
          1:       entry_d = cfg_delay(8'd10);
          2:       entry_d = cfg_write(REG_CLKRC, 8'h01);
          3:       entry_d = cfg_write(REG_COM7, 8'h04);
          4:       entry_d = cfg_write(REG_COM15, 8'hD0);
          5:       entry_d = cfg_write(REG_RGB444, 8'h00);
          6:       entry_d = cfg_write(REG_TSLB, 8'h04);
          7:       entry_d = cfg_write(REG_COM3, 8'h00);
          8:       entry_d = cfg_write(REG_COM14, 8'h00);
          default: entry_d = CFG_SENTINEL;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM once per i_start and hands each {reg, value}
// write to the SCCB engine, honouring embedded millisecond delays.
module ov7670_config_sequencer
  import ov7670_config_sequencer_pkg::*;
#(
  parameter int         ClockFrequency = 50_000_000,
  parameter int         PowerUpDelayMs = 10,
  parameter int         GapCycles      = 64,
  parameter int         AcceptTimeout  = 16,
  parameter int         RomDepth       = 128,
  parameter cfg_table_e Table          = TBL_OV7670_RGB565,
  localparam int        IdxW           = $clog2(RomDepth)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_start,
  ov7670_config_sequencer_if.master sccb,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [IdxW-1:0]           o_index,
  output seq_state_e                o_state
);

  localparam int TickMax = ClockFrequency / 1000 - 1;
  localparam int TickW   = $clog2(TickMax + 2);

  seq_state_e      state_q;
  logic [IdxW-1:0] index_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic [TickW-1:0] tick_q;
  logic [15:0]     ms_q;
  logic [7:0]      delay_ms_q;
  logic [15:0]     cyc_q;

  logic [15:0] rom_entry;
  logic        tick_en;
  logic        step_done;

  ov7670_config_rom #(
    .Table    (Table),
    .RomDepth (RomDepth)
  ) u_rom (
    .clk_i   (CLK),
    .index_i (index_q),
    .entry_o (rom_entry)
  );

  assign tick_en   = (state_q == ST_POWERUP) || (state_q == ST_DELAY);
  assign step_done = (state_q == ST_GAP) ? (cyc_q == 16'(GapCycles - 1))
                                         : (ms_q >= {8'h00, delay_ms_q});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= '0;
      ms_q       <= '0;
      delay_ms_q <= '0;
      cyc_q      <= '0;
    end else begin
      ready_q <= 1'b0;
      if (tick_en) begin
        if (tick_q == TickW'(TickMax)) begin
          tick_q <= '0;
          ms_q   <= ms_q + 16'd1;
        end else begin
          tick_q <= tick_q + TickW'(1);
        end
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_q <= ST_POWERUP;
            index_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tick_q  <= '0;
            ms_q    <= '0;
          end
        end
        ST_POWERUP: if (ms_q >= 16'(PowerUpDelayMs)) state_q <= ST_FETCH;
        ST_FETCH:   state_q <= ST_DECODE;
        ST_DECODE: begin
          if (rom_entry == CFG_SENTINEL) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (rom_entry[15:8] == CFG_DELAY_TAG) begin
            delay_ms_q <= rom_entry[7:0];
            tick_q     <= '0;
            ms_q       <= '0;
            state_q    <= ST_DELAY;
          end else begin
            addr_q  <= rom_entry[15:8];
            data_q  <= rom_entry[7:0];
            state_q <= ST_ISSUE;
          end
        end
        // A busy engine here is a transfer already in flight; treat it as accepted.
        ST_ISSUE: begin
          if (sccb.i_sccb_busy) begin
            state_q <= ST_WAIT_FREE;
          end else begin
            ready_q <= 1'b1;
            cyc_q   <= '0;
            state_q <= ST_WAIT_ACCEPT;
          end
        end
        ST_WAIT_ACCEPT: begin
          if (sccb.i_sccb_busy)                         state_q <= ST_WAIT_FREE;
          else if (cyc_q == 16'(AcceptTimeout - 1))     state_q <= ST_ISSUE;
          else                                          cyc_q   <= cyc_q + 16'd1;
        end
        ST_WAIT_FREE: begin
          if (!sccb.i_sccb_busy) begin
            cyc_q   <= '0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP, ST_DELAY: begin
          if (state_q == ST_GAP) cyc_q <= cyc_q + 16'd1;
          if (step_done) begin
            // The last slot ends the run even without a sentinel; the index never wraps.
            if (index_q == IdxW'(RomDepth - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= index_q + IdxW'(1);
              state_q <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sccb.o_addr  = addr_q;
  assign sccb.o_data  = data_q;
  assign sccb.o_ready = ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_index      = index_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench: two sequencer instances driven by a behavioural SCCB engine
// (busy rises 2 cycles after ready, held 100 cycles).
module tb_ov7670_config_sequencer;
  import ov7670_config_sequencer_pkg::*;

  localparam int ClkHz   = 100_000;
  localparam int Gap     = 64;
  localparam int Timeout = 16;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [6:0] idx_a;
  logic [1:0] idx_b;
  seq_state_e st_a, st_b;

  ov7670_config_sequencer_if ifa ();
  ov7670_config_sequencer_if ifb ();

  ov7670_config_sequencer #(
    .ClockFrequency (ClkHz), .PowerUpDelayMs (1), .GapCycles (Gap),
    .AcceptTimeout (Timeout), .RomDepth (128), .Table (TBL_SOFT_RESET)
  ) dut_a (
    .CLK (clk), .RST (rst), .i_start (start_a), .sccb (ifa.master),
    .o_busy (busy_a), .o_done (done_a), .o_index (idx_a), .o_state (st_a)
  );

  ov7670_config_sequencer #(
    .ClockFrequency (ClkHz), .PowerUpDelayMs (1), .GapCycles (Gap),
    .AcceptTimeout (Timeout), .RomDepth (4), .Table (TBL_WRITES_ONLY)
  ) dut_b (
    .CLK (clk), .RST (rst), .i_start (start_b), .sccb (ifb.master),
    .o_busy (busy_b), .o_done (done_b), .o_index (idx_b), .o_state (st_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int rdy_t_a[$];
  int wr_a = 0, wr_b = 0;
  int pend_a = 0, hold_a = 0, run_a = 0, pend_b = 0, hold_b = 0, run_b = 0;
  int last_fall_a = -1, gap_a = 0;
  logic ignore_a = 1'b0;
  logic [15:0] wr_val_a, wr_val_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // engine model + monitor, instance A
  always @(negedge clk) begin
    if (rst) begin
      ifa.i_sccb_busy = 1'b0; pend_a = 0; hold_a = 0; run_a = 0;
    end else begin
      if (ifa.o_ready) begin
        if (run_a == 0) begin
          rdy_t_a.push_back(cyc);
          if (last_fall_a >= 0) gap_a = cyc - last_fall_a;
          check("a_ready_while_busy", 32'(ifa.i_sccb_busy), 0);
        end
        run_a++;
      end else if (run_a != 0) begin
        check("a_ready_width", run_a, 1);
        run_a = 0;
      end
      if (hold_a > 0) begin
        hold_a--;
        if (hold_a == 0) begin
          ifa.i_sccb_busy = 1'b0;
          last_fall_a = cyc;
          check("a_hold_addr_data", {ifa.o_addr, ifa.o_data}, wr_val_a);
        end
      end else if (pend_a > 0) begin
        pend_a--;
        if (pend_a == 0) begin ifa.i_sccb_busy = 1'b1; hold_a = 100; end
      end
      if (ifa.o_ready && run_a == 1) begin
        if (ignore_a) ignore_a = 1'b0;
        else begin
          pend_a = 2; wr_a++;
          wr_val_a = {ifa.o_addr, ifa.o_data};
          check("a_write_expected", 32'(exp_a.size() != 0), 1);
          if (exp_a.size() != 0) check("a_write_value", wr_val_a, exp_a.pop_front());
        end
      end
    end
  end

  // engine model + monitor, instance B
  always @(negedge clk) begin
    if (rst) begin
      ifb.i_sccb_busy = 1'b0; pend_b = 0; hold_b = 0; run_b = 0;
    end else begin
      if (ifb.o_ready) run_b++;
      else if (run_b != 0) begin check("b_ready_width", run_b, 1); run_b = 0; end
      if (hold_b > 0) begin
        hold_b--;
        if (hold_b == 0) begin
          ifb.i_sccb_busy = 1'b0;
          check("b_hold_addr_data", {ifb.o_addr, ifb.o_data}, wr_val_b);
        end
      end else if (pend_b > 0) begin
        pend_b--;
        if (pend_b == 0) begin ifb.i_sccb_busy = 1'b1; hold_b = 100; end
      end
      if (ifb.o_ready && run_b == 1) begin
        pend_b = 2; wr_b++;
        wr_val_b = {ifb.o_addr, ifb.o_data};
        check("b_write_expected", 32'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) check("b_write_value", wr_val_b, exp_b.pop_front());
      end
    end
  end

  // driver tasks
  task automatic pulse(input bit sel_b);
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sel_b ? done_b : done_a) break;
      @(negedge clk);
    end
    check(sel_b ? "b_done_reached" : "a_done_reached", 32'(sel_b ? done_b : done_a), 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_addr"}, ifa.o_addr, 8'h00);
    check({tag, "_data"}, ifa.o_data, 8'h00);
    check({tag, "_ready"}, ifa.o_ready, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_index"}, idx_a, 0);
    check({tag, "_state"}, 32'(st_a), 32'(ST_IDLE));
  endtask

  task automatic load_exp_a();
    exp_a.delete();
    exp_a.push_back(16'h1280);
    exp_a.push_back(16'h1101);
    wr_a = 0;
    rdy_t_a.delete();
  endtask

  int spacing;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Soft reset write, 1 ms delay entry, CLKRC write; stray i_start mid-run.
    load_exp_a();
    pulse(0);
    check("a_busy_on_start", busy_a, 1);
    check("a_done_low_on_start", done_a, 0);
    for (int i = 0; i < 2000 && wr_a == 0; i++) @(negedge clk);
    pulse(0);
    check("a_start_ignored", 32'(st_a == ST_POWERUP), 0);
    wait_done(0, 3000);
    check("a_run1_busy_end", busy_a, 0);
    check("a_run1_writes", wr_a, 2);
    check("a_run1_exp_left", exp_a.size(), 0);
    check("a_run1_hold_last", {ifa.o_addr, ifa.o_data}, 16'h1101);
    // busy fall -> next ready spans the 64-cycle gap plus the 1 ms (100-cycle) delay
    check("a_run1_ms_gap", 32'(gap_a >= Gap + 100), 1);

    // Engine ignores the first request; rerun from DONE clears o_done at once.
    load_exp_a();
    ignore_a = 1'b1;
    pulse(0);
    check("a_rerun_done_clr", done_a, 0);
    check("a_rerun_busy", busy_a, 1);
    check("a_rerun_index", idx_a, 0);
    wait_done(0, 3000);
    // 16 cycles of unanswered WAIT_ACCEPT, then one ISSUE cycle
    spacing = (rdy_t_a.size() >= 2) ? rdy_t_a[1] - rdy_t_a[0] : -1;
    check("a_repulse_spacing", spacing, Timeout + 1);
    check("a_repulse_ready_count", rdy_t_a.size(), 3);
    check("a_repulse_writes", wr_a, 2);
    check("a_repulse_exp_left", exp_a.size(), 0);

    // Reset during WAIT_FREE of the second write, then rerun from index 0.
    load_exp_a();
    pulse(0);
    for (int i = 0; i < 2000 && !(wr_a == 2 && ifa.i_sccb_busy); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("a_in_wait_free", 32'(st_a), 32'(ST_WAIT_FREE));
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    load_exp_a();
    pulse(0);
    check("a_after_rst_index", idx_a, 0);
    wait_done(0, 3000);
    check("a_after_rst_writes", wr_a, 2);
    check("a_after_rst_exp_left", exp_a.size(), 0);

    // No sentinel in a 4-deep table: all four slots written, then DONE at index 3.
    exp_b.delete();
    exp_b.push_back(16'h1101);
    exp_b.push_back(16'h3A04);
    exp_b.push_back(16'h40D0);
    exp_b.push_back(16'h8C00);
    wr_b = 0;
    pulse(1);
    check("b_busy_on_start", busy_b, 1);
    wait_done(1, 3000);
    check("b_busy_end", busy_b, 0);
    check("b_index_end", idx_b, 3);
    check("b_writes", wr_b, 4);
    check("b_exp_left", exp_b.size(), 0);
    repeat (20) @(negedge clk);
    check("b_index_stays", idx_b, 3);
    check("b_done_stays", done_b, 1);
    check("b_no_more_ready", run_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
